// File: rtl/riscv_core_hazard_pkg.sv
// Hazard controller shared types and constants.
// State encoding, register width, parameter bounds.
package riscv_core_hazard_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH,
    ST_RUN,
    ST_MC_BUSY,
    ST_MEM_WAIT
  } state_e;

  localparam int REG_W     = 5;
  localparam int MC_LAT_LO = 2;
  localparam int MC_LAT_HI = 32;
  localparam int FLUSH_LO  = 1;
  localparam int FLUSH_HI  = 8;

  // Counter width able to hold n-1, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/riscv_core_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in,
// per-stage stall/clear requests out.
interface riscv_core_hazard_ctrl_if;
  import riscv_core_hazard_pkg::*;

  logic [REG_W-1:0] ID_RS1;
  logic [REG_W-1:0] ID_RS2;
  logic             ID_USES_RS1;
  logic             ID_USES_RS2;
  logic [REG_W-1:0] EX_RD;
  logic             EX_IS_LOAD;
  logic             EX_REDIRECT;
  logic             EX_MC_START;
  logic             ME_REQ;
  logic             ME_READY;

  logic IF_STALL_D;
  logic ID_STALL_D;
  logic EX_STALL_D;
  logic ME_STALL_D;
  logic WB_STALL_D;
  logic ID_CLEAR_D;
  logic EX_CLEAR_D;
  logic ME_CLEAR_D;
  logic WB_CLEAR_D;
  logic BUSY;

  modport master (
    output ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
    output EX_RD, EX_IS_LOAD, EX_REDIRECT, EX_MC_START,
    output ME_REQ, ME_READY,
    input  IF_STALL_D, ID_STALL_D, EX_STALL_D,
    input  ME_STALL_D, WB_STALL_D,
    input  ID_CLEAR_D, EX_CLEAR_D, ME_CLEAR_D, WB_CLEAR_D,
    input  BUSY
  );

  modport slave (
    input  ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
    input  EX_RD, EX_IS_LOAD, EX_REDIRECT, EX_MC_START,
    input  ME_REQ, ME_READY,
    output IF_STALL_D, ID_STALL_D, EX_STALL_D,
    output ME_STALL_D, WB_STALL_D,
    output ID_CLEAR_D, EX_CLEAR_D, ME_CLEAR_D, WB_CLEAR_D,
    output BUSY
  );

endinterface

// File: rtl/riscv_core_hazard_cnt.sv
// Loadable down-counter, saturating at zero.
// Reset value is a parameter so it can seed a sequence.
module riscv_core_hazard_cnt #(
  parameter int         W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         LOAD,
  input  logic [W-1:0] LOAD_VAL,
  input  logic         DEC,
  output logic [W-1:0] CNT,
  output logic         ZERO
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over decrement; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (LOAD) begin
      cnt_d = LOAD_VAL;
    end else if (DEC && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= RST_VAL;
    else        cnt_q <= cnt_d;
  end

  assign CNT  = cnt_q;
  assign ZERO = (cnt_q == '0);

endmodule

// File: rtl/riscv_core_hazard_ctrl.sv
// Pipeline hazard controller: load-use, redirect,
// multicycle EX, memory wait and post-reset flush.
module riscv_core_hazard_ctrl
  import riscv_core_hazard_pkg::*;
#(
  parameter int MC_LATENCY   = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input logic CLK,
  input logic RST_N,
  riscv_core_hazard_ctrl_if.slave hz
);

  localparam int MW = cnt_w(MC_LATENCY);
  localparam int FW = cnt_w(FLUSH_CYCLES);
  localparam logic [MW-1:0] MC_LOAD = MW'(MC_LATENCY - 1);
  localparam logic [FW-1:0] FL_INIT = FW'(FLUSH_CYCLES - 1);

  if (MC_LATENCY < MC_LAT_LO || MC_LATENCY > MC_LAT_HI)
  begin : g_bad_mc
    $error("MC_LATENCY out of range");
  end
  if (FLUSH_CYCLES < FLUSH_LO || FLUSH_CYCLES > FLUSH_HI)
  begin : g_bad_fl
    $error("FLUSH_CYCLES out of range");
  end

  state_e state_q;
  state_e state_d;

  logic          flushing;
  logic          mem_wait;
  logic          mc_start;
  logic          mc_busy;
  logic          mc_more;
  logic          load_use;
  logic          flush_zero;
  logic          mc_zero;
  logic [MW-1:0] mc_cnt;

  riscv_core_hazard_cnt #(
    .W       (FW),
    .RST_VAL (FL_INIT)
  ) u_flush_cnt (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .LOAD     (1'b0),
    .LOAD_VAL ('0),
    .DEC      (flushing),
    .CNT      (),
    .ZERO     (flush_zero)
  );

  riscv_core_hazard_cnt #(
    .W       (MW),
    .RST_VAL ('0)
  ) u_mc_cnt (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .LOAD     (mc_start),
    .LOAD_VAL (MC_LOAD),
    .DEC      (1'b1),
    .CNT      (mc_cnt),
    .ZERO     (mc_zero)
  );

  // Hazard conditions seen this cycle.
  always_comb begin
    flushing = (state_q == ST_FLUSH);
    mem_wait = hz.ME_REQ & ~hz.ME_READY;
    mc_start = hz.EX_MC_START & ~flushing;
    mc_busy  = ~mc_zero | mc_start;
    mc_more  = mc_start | (mc_cnt > MW'(1));
    load_use = hz.EX_IS_LOAD & (hz.EX_RD != '0) &
               ((hz.ID_USES_RS1 & (hz.ID_RS1 == hz.EX_RD)) |
                (hz.ID_USES_RS2 & (hz.ID_RS2 == hz.EX_RD)));
  end

  // Next state: memory wait dominates, MC unit runs alongside.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FLUSH:
        state_d = flush_zero ? ST_RUN : ST_FLUSH;
      ST_RUN, ST_MC_BUSY, ST_MEM_WAIT:
        if (mem_wait)     state_d = ST_MEM_WAIT;
        else if (mc_more) state_d = ST_MC_BUSY;
        else              state_d = ST_RUN;
      default:
        state_d = ST_FLUSH;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_FLUSH;
    else        state_q <= state_d;
  end

  // Prioritised stall/clear requests; higher masks lower.
  always_comb begin
    hz.IF_STALL_D = 1'b0;
    hz.ID_STALL_D = 1'b0;
    hz.EX_STALL_D = 1'b0;
    hz.ME_STALL_D = 1'b0;
    hz.WB_STALL_D = 1'b0;
    hz.ID_CLEAR_D = 1'b0;
    hz.EX_CLEAR_D = 1'b0;
    hz.ME_CLEAR_D = 1'b0;
    hz.WB_CLEAR_D = 1'b0;
    hz.BUSY       = (state_q != ST_RUN);
    if (flushing) begin
      hz.ID_CLEAR_D = 1'b1;
      hz.EX_CLEAR_D = 1'b1;
      hz.ME_CLEAR_D = 1'b1;
      hz.WB_CLEAR_D = 1'b1;
    end else if (mem_wait) begin
      hz.IF_STALL_D = 1'b1;
      hz.ID_STALL_D = 1'b1;
      hz.EX_STALL_D = 1'b1;
      hz.ME_STALL_D = 1'b1;
      hz.WB_CLEAR_D = 1'b1;
    end else if (mc_busy) begin
      hz.IF_STALL_D = 1'b1;
      hz.ID_STALL_D = 1'b1;
      hz.EX_STALL_D = 1'b1;
      hz.ME_CLEAR_D = 1'b1;
    end else if (hz.EX_REDIRECT) begin
      hz.ID_CLEAR_D = 1'b1;
      hz.EX_CLEAR_D = 1'b1;
    end else if (load_use) begin
      hz.IF_STALL_D = 1'b1;
      hz.ID_STALL_D = 1'b1;
      hz.EX_CLEAR_D = 1'b1;
    end
  end

endmodule
